// File: rtl/sr_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// sr_cmd_sequencer
//   Command stage that sits in front of a downstream SR flip-flop. Two
//   asynchronous request levels (set/clear) are synchronised, debounced and
//   edge-detected into pending flags. A small FSM then services one flag at a
//   time, either skipping it (flop already at the target) or issuing a single
//   cycle s/r pulse and confirming the flop output through q_fb. A missing
//   confirmation parks the FSM in ERR until err_clr.
//
// Ports
//   clk      in   1      clock, rising edge
//   rst      in   1      asynchronous reset, active low
//   set_btn  in   1      asynchronous set request level
//   clr_btn  in   1      asynchronous clear request level
//   q_fb     in   1      q of the downstream SR flop
//   err_clr  in   1      synchronous pulse that leaves ERR
//   s        out  1      set pulse to the SR flop (registered)
//   r        out  1      reset pulse to the SR flop (registered)
//   busy     out  1      FSM not in IDLE (registered)
//   err      out  1      FSM in ERR (registered)
//   cmd_cnt  out  CNT_W  number of confirmed commands, wraps
// -----------------------------------------------------------------------------
module sr_cmd_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CONFIRM_CYCLES  = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_btn,
    input  logic             clr_btn,
    input  logic             q_fb,
    input  logic             err_clr,
    output logic             s,
    output logic             r,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] cmd_cnt
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CF_W = $clog2(CONFIRM_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    // Index 0 is the set channel, index 1 the clear channel.
    logic [1:0]      sync1_q;
    logic [1:0]      sync2_q;
    logic [1:0]      filt_q;
    logic [1:0]      filt_d;
    logic [1:0]      filt_dly_q;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];
    logic [1:0]      rise_s;

    logic            set_pend_q;
    logic            set_pend_d;
    logic            clr_pend_q;
    logic            clr_pend_d;

    state_t          state_q;
    state_t          state_d;
    logic            target_q;
    logic            target_d;
    logic [CF_W-1:0] wait_cnt_q;
    logic [CF_W-1:0] wait_cnt_d;
    logic [CNT_W-1:0] cmd_cnt_q;
    logic [CNT_W-1:0] cmd_cnt_d;

    logic            set_consume_s;
    logic            clr_consume_s;
    logic            clr_all_s;

    logic            s_q;
    logic            s_d;
    logic            r_q;
    logic            r_d;
    logic            busy_q;
    logic            busy_d;
    logic            err_q;
    logic            err_d;

    // Debounce: filtered level follows the synced level only after a full run
    // of consecutive mismatching edges; any agreeing edge restarts the run.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (sync2_q[i] != filt_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    filt_d[i]   = sync2_q[i];
                    db_cnt_d[i] = {DB_W{1'b0}};
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + {{(DB_W-1){1'b0}}, 1'b1};
                end
            end else begin
                db_cnt_d[i] = {DB_W{1'b0}};
            end
        end
    end

    // Rising edge of the filtered level, one cycle after it changes.
    assign rise_s = filt_q & ~filt_dly_q;

    // FSM next state, command bookkeeping and pending-flag consumption.
    always_comb begin
        state_d       = state_q;
        target_d      = target_q;
        wait_cnt_d    = wait_cnt_q;
        cmd_cnt_d     = cmd_cnt_q;
        set_consume_s = 1'b0;
        clr_consume_s = 1'b0;
        clr_all_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Clear wins over set, so simultaneous requests end at q=1.
                if (clr_pend_q) begin
                    clr_consume_s = 1'b1;
                    if (q_fb != 1'b0) begin
                        target_d = 1'b0;
                        state_d  = ST_ISSUE;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end else if (set_pend_q) begin
                    set_consume_s = 1'b1;
                    if (q_fb != 1'b1) begin
                        target_d = 1'b1;
                        state_d  = ST_ISSUE;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d    = ST_WAIT;
                wait_cnt_d = {CF_W{1'b0}};
            end
            ST_WAIT: begin
                if (q_fb == target_q) begin
                    cmd_cnt_d = cmd_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d   = ST_IDLE;
                end else if (wait_cnt_q == CF_W'(CONFIRM_CYCLES - 1)) begin
                    state_d   = ST_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + {{(CF_W-1){1'b0}}, 1'b1};
                end
            end
            ST_ERR: begin
                if (err_clr) begin
                    state_d   = ST_IDLE;
                    clr_all_s = 1'b1;
                end else begin
                    state_d   = ST_ERR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pending flags: a new rise beats consumption of the same flag, so a
    // request arriving while its older twin is serviced is not lost.
    always_comb begin
        set_pend_d = set_pend_q;
        clr_pend_d = clr_pend_q;
        if (clr_all_s) begin
            set_pend_d = 1'b0;
            clr_pend_d = 1'b0;
        end else begin
            if (set_consume_s) begin
                set_pend_d = 1'b0;
            end else begin
                set_pend_d = set_pend_q;
            end
            if (clr_consume_s) begin
                clr_pend_d = 1'b0;
            end else begin
                clr_pend_d = clr_pend_q;
            end
            if (rise_s[0] && (state_q != ST_ERR)) begin
                set_pend_d = 1'b1;
            end else begin
                set_pend_d = set_pend_d;
            end
            if (rise_s[1] && (state_q != ST_ERR)) begin
                clr_pend_d = 1'b1;
            end else begin
                clr_pend_d = clr_pend_d;
            end
        end
    end

    // Outputs decoded from the next state so they come straight off flops.
    always_comb begin
        s_d    = (state_d == ST_ISSUE) &&  target_d;
        r_d    = (state_d == ST_ISSUE) && !target_d;
        busy_d = (state_d != ST_IDLE);
        err_d  = (state_d == ST_ERR);
    end

    // State register for synchronisers, debounce, flags, FSM and outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q     <= 2'b00;
            sync2_q     <= 2'b00;
            filt_q      <= 2'b00;
            filt_dly_q  <= 2'b00;
            db_cnt_q[0] <= {DB_W{1'b0}};
            db_cnt_q[1] <= {DB_W{1'b0}};
            set_pend_q  <= 1'b0;
            clr_pend_q  <= 1'b0;
            state_q     <= ST_IDLE;
            target_q    <= 1'b0;
            wait_cnt_q  <= {CF_W{1'b0}};
            cmd_cnt_q   <= {CNT_W{1'b0}};
            s_q         <= 1'b0;
            r_q         <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sync1_q     <= {clr_btn, set_btn};
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            filt_dly_q  <= filt_q;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
            set_pend_q  <= set_pend_d;
            clr_pend_q  <= clr_pend_d;
            state_q     <= state_d;
            target_q    <= target_d;
            wait_cnt_q  <= wait_cnt_d;
            cmd_cnt_q   <= cmd_cnt_d;
            s_q         <= s_d;
            r_q         <= r_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign s       = s_q;
    assign r       = r_q;
    assign busy    = busy_q;
    assign err     = err_q;
    assign cmd_cnt = cmd_cnt_q;

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sr_cmd_sequencer
//   Directed scenarios (reset, set path timing, glitch, redundant request,
//   simultaneous requests, confirmation timeout, reset mid-pulse) followed by
//   random request transactions checked against a transaction-level model of
//   the SR flop state, command count and pulse counts.
// -----------------------------------------------------------------------------
module tb_sr_cmd_sequencer;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       set_btn = 1'b0;
    logic       clr_btn = 1'b0;
    logic       err_clr = 1'b0;
    logic       q_fb;
    logic       s;
    logic       r;
    logic       busy;
    logic       err;
    logic [7:0] cmd_cnt;

    logic       q_sr    = 1'b0;
    logic       tie_q0  = 1'b0;

    int tests = 0;
    int fails = 0;
    int s_pulses = 0;
    int r_pulses = 0;
    int overlap  = 0;

    assign q_fb = tie_q0 ? 1'b0 : q_sr;

    sr_cmd_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .CONFIRM_CYCLES  (4),
        .CNT_W           (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .set_btn (set_btn),
        .clr_btn (clr_btn),
        .q_fb    (q_fb),
        .err_clr (err_clr),
        .s       (s),
        .r       (r),
        .busy    (busy),
        .err     (err),
        .cmd_cnt (cmd_cnt)
    );

    always #5 clk = ~clk;

    // Downstream SR flop.
    always @(posedge clk) begin
        if (s === 1'b1) q_sr <= 1'b1;
        else if (r === 1'b1) q_sr <= 1'b0;
    end

    // Pulse monitor.
    always @(posedge clk) begin
        if (s === 1'b1) s_pulses++;
        if (r === 1'b1) r_pulses++;
        if (s === 1'b1 && r === 1'b1) overlap++;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold the chosen buttons for hold cycles, release, then let it settle.
    task automatic press(input logic do_set, input logic do_clr, input int hold);
        set_btn = do_set;
        clr_btn = do_clr;
        tick(hold);
        set_btn = 1'b0;
        clr_btn = 1'b0;
        tick(30);
    endtask

    initial begin
        int s0;
        int r0;
        int exp_cnt;
        logic exp_q;
        int kind;
        int exp_s;
        int exp_r;

        // T1: reset with a request present
        #1;
        rst     = 1'b0;
        set_btn = 1'b1;
        tick(2);
        check("t1_s",    32'(s),       32'd0);
        check("t1_r",    32'(r),       32'd0);
        check("t1_busy", 32'(busy),    32'd0);
        check("t1_err",  32'(err),     32'd0);
        check("t1_cnt",  32'(cmd_cnt), 32'd0);
        rst = 1'b1;
        tick(1);
        check("t1_rel1", 32'({s, r, busy, err}), 32'd0);
        tick(1);
        check("t1_rel2", 32'({s, r, busy, err}), 32'd0);
        set_btn = 1'b0;
        tick(20);
        check("t1_nopulse", 32'(s_pulses + r_pulses), 32'd0);

        // T2: set path timing, s only in the cycle after E7
        set_btn = 1'b1;
        tick(7);
        check("t2_s_e6", 32'(s), 32'd0);
        tick(1);
        check("t2_s_e7",    32'(s),    32'd1);
        check("t2_r_e7",    32'(r),    32'd0);
        check("t2_busy_e7", 32'(busy), 32'd1);
        tick(1);
        check("t2_s_e8",    32'(s),    32'd0);
        check("t2_q_e8",    32'(q_sr), 32'd1);
        check("t2_busy_e8", 32'(busy), 32'd1);
        tick(1);
        check("t2_busy_e9", 32'(busy),    32'd0);
        check("t2_cnt",     32'(cmd_cnt), 32'd1);
        set_btn = 1'b0;
        tick(20);
        check("t2_one_s", 32'(s_pulses), 32'd1);

        // T3: short glitch ignored
        s0 = s_pulses;
        press(1'b1, 1'b0, 3);
        check("t3_glitch_s",    32'(s_pulses - s0), 32'd0);
        check("t3_glitch_busy", 32'(busy),          32'd0);
        // clear from q=1, then a redundant clear
        r0 = r_pulses;
        press(1'b0, 1'b1, 8);
        check("t3_clr_r",   32'(r_pulses - r0), 32'd1);
        check("t3_clr_q",   32'(q_sr),          32'd0);
        check("t3_clr_cnt", 32'(cmd_cnt),       32'd2);
        r0 = r_pulses;
        press(1'b0, 1'b1, 8);
        check("t3_redund_r",   32'(r_pulses - r0), 32'd0);
        check("t3_redund_cnt", 32'(cmd_cnt),       32'd2);
        press(1'b1, 1'b0, 8);
        check("t3_set_cnt", 32'(cmd_cnt), 32'd3);

        // T4: simultaneous requests from q=1
        s0 = s_pulses;
        r0 = r_pulses;
        press(1'b1, 1'b1, 8);
        check("t4_r",       32'(r_pulses - r0), 32'd1);
        check("t4_s",       32'(s_pulses - s0), 32'd1);
        check("t4_q",       32'(q_sr),          32'd1);
        check("t4_cnt",     32'(cmd_cnt),       32'd5);
        check("t4_overlap", 32'(overlap),       32'd0);

        // T5: confirmation timeout
        tie_q0  = 1'b1;
        s0      = s_pulses;
        set_btn = 1'b1;
        tick(12);
        check("t5_err_early", 32'(err), 32'd0);
        tick(1);
        check("t5_err",      32'(err),           32'd1);
        check("t5_busy",     32'(busy),          32'd1);
        check("t5_one_s",    32'(s_pulses - s0), 32'd1);
        set_btn = 1'b0;
        tick(20);
        s0 = s_pulses;
        press(1'b1, 1'b0, 8);
        check("t5_ignored_s", 32'(s_pulses - s0), 32'd0);
        check("t5_still_err", 32'(err),           32'd1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("t5_cleared_err",  32'(err),  32'd0);
        check("t5_cleared_busy", 32'(busy), 32'd0);
        tick(20);
        check("t5_no_reissue", 32'(s_pulses - s0), 32'd0);
        check("t5_cnt",        32'(cmd_cnt),       32'd5);

        // T6: reset during the ISSUE cycle
        set_btn = 1'b1;
        tick(8);
        check("t6_s_issue", 32'(s), 32'd1);
        #2;
        rst     = 1'b0;
        set_btn = 1'b0;
        #1;
        check("t6_s_async",    32'(s),       32'd0);
        check("t6_busy_async", 32'(busy),    32'd0);
        check("t6_cnt_async",  32'(cmd_cnt), 32'd0);
        tick(2);
        rst = 1'b1;
        s0  = s_pulses;
        tick(20);
        check("t6_idle",     32'({busy, err}),   32'd0);
        check("t6_no_pulse", 32'(s_pulses - s0), 32'd0);
        tie_q0 = 1'b0;

        // Random transactions against the request-level model
        exp_cnt = 0;
        exp_q   = 1'b1;
        for (int t = 0; t < 24; t++) begin
            kind  = $urandom_range(0, 3);
            s0    = s_pulses;
            r0    = r_pulses;
            exp_s = 0;
            exp_r = 0;
            case (kind)
                0: begin
                    if (!exp_q) begin exp_s = 1; exp_q = 1'b1; exp_cnt++; end
                    press(1'b1, 1'b0, $urandom_range(6, 12));
                end
                1: begin
                    if (exp_q) begin exp_r = 1; exp_q = 1'b0; exp_cnt++; end
                    press(1'b0, 1'b1, $urandom_range(6, 12));
                end
                2: begin
                    if (exp_q) begin exp_r = 1; exp_cnt++; end
                    exp_s = 1;
                    exp_q = 1'b1;
                    exp_cnt++;
                    press(1'b1, 1'b1, $urandom_range(6, 12));
                end
                default: begin
                    press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom_range(1, 3));
                end
            endcase
            check("rnd_busy", 32'(busy),           32'd0);
            check("rnd_q",    32'(q_sr),           32'(exp_q));
            check("rnd_cnt",  32'(cmd_cnt),        32'(exp_cnt & 8'hFF));
            check("rnd_s",    32'(s_pulses - s0),  32'(exp_s));
            check("rnd_r",    32'(r_pulses - r0),  32'(exp_r));
        end
        check("overlap_total", 32'(overlap), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
